// File: rtl/i2c_pkg.sv
// ============================================================================
// Module   : i2c_pkg
// Purpose  : Shared I2C state encoding and bit-level constants.
// Revision : 1.0
// ============================================================================
`default_nettype none

package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_IGNORE    = 4'd9
  } i2c_state_e;

  localparam logic c_ack      = 1'b0;
  localparam logic c_nack     = 1'b1;
  localparam logic c_rw_write = 1'b0;
  localparam logic c_rw_read  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/i2c_line_filter.sv
// ============================================================================
// Module   : i2c_line_filter
// Purpose  : Two-flop synchronizer plus N-sample glitch filter for one line.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_line_filter #(
  parameter int FILTER_CYCLES = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int            c_cnt_w    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILTER_CYCLES - 1);

  logic [1:0]         r_sync;
  logic               r_level;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_rise;
  logic               r_fall;

  // The level only flips after FILTER_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_rise  <= r_sync[1];
        r_fall  <= ~r_sync[1];
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/i2c_target.sv
// ============================================================================
// Module   : i2c_target
// Purpose  : I2C target exposing an 8-bit-addressed register window.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS       = 7'h30,
  parameter int         FILTER_CYCLES = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i2c_scl_in,
  input  logic       i2c_sda_in,
  output logic       i2c_sda_drive_n,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl_filter (
    .clk     (clk),
    .resetn  (resetn),
    .i_line  (i2c_scl_in),
    .o_level (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda_filter (
    .clk     (clk),
    .resetn  (resetn),
    .i_line  (i2c_sda_in),
    .o_level (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  i2c_state_e r_state, w_state_nxt;
  logic [3:0] r_bitcnt, w_bitcnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_sda_drive_n, w_sda_drive_n_nxt;
  logic [7:0] r_addr, w_addr_nxt;
  logic [7:0] r_wdata, w_wdata_nxt;
  logic       r_we, w_we_nxt;
  logic       r_re, w_re_nxt;
  logic       r_re_d;
  logic       r_busy, w_busy_nxt;
  logic       r_rw, w_rw_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_bitcnt      <= 4'd0;
      r_shift       <= 8'h00;
      r_sda_drive_n <= 1'b1;
      r_addr        <= 8'h00;
      r_wdata       <= 8'h00;
      r_we          <= 1'b0;
      r_re          <= 1'b0;
      r_re_d        <= 1'b0;
      r_busy        <= 1'b0;
      r_rw          <= c_rw_write;
    end else begin
      r_state       <= w_state_nxt;
      r_bitcnt      <= w_bitcnt_nxt;
      r_shift       <= w_shift_nxt;
      r_sda_drive_n <= w_sda_drive_n_nxt;
      r_addr        <= w_addr_nxt;
      r_wdata       <= w_wdata_nxt;
      r_we          <= w_we_nxt;
      r_re          <= w_re_nxt;
      r_re_d        <= r_re;
      r_busy        <= w_busy_nxt;
      r_rw          <= w_rw_nxt;
    end
  end

  // Bits are counted on SCL rise; byte completion acts on the following fall
  // so the ACK drive and the first read bit both change while SCL is low.
  always_comb begin
    w_state_nxt       = r_state;
    w_bitcnt_nxt      = r_bitcnt;
    w_shift_nxt       = r_shift;
    w_sda_drive_n_nxt = r_sda_drive_n;
    w_addr_nxt        = r_addr;
    w_wdata_nxt       = r_wdata;
    w_we_nxt          = 1'b0;
    w_re_nxt          = 1'b0;
    w_busy_nxt        = r_busy;
    w_rw_nxt          = r_rw;

    if (r_we) w_addr_nxt = r_addr + 8'd1;
    if (r_re_d) w_shift_nxt = reg_rdata;

    if (w_start) begin
      w_state_nxt       = ST_ADDR;
      w_bitcnt_nxt      = 4'd0;
      w_sda_drive_n_nxt = 1'b1;
    end else if (w_stop) begin
      w_state_nxt       = ST_IDLE;
      w_bitcnt_nxt      = 4'd0;
      w_sda_drive_n_nxt = 1'b1;
      w_busy_nxt        = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (w_scl_rise && r_bitcnt != 4'd8) begin
            w_shift_nxt  = {r_shift[6:0], w_sda};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_scl_fall && r_bitcnt == 4'd8) begin
            w_bitcnt_nxt = 4'd0;
            if (r_state == ST_ADDR) begin
              if (r_shift[7:1] == ADDRESS) begin
                w_state_nxt       = ST_ADDR_ACK;
                w_sda_drive_n_nxt = c_ack;
                w_busy_nxt        = 1'b1;
                w_rw_nxt          = r_shift[0];
              end else begin
                w_state_nxt       = ST_IGNORE;
                w_sda_drive_n_nxt = 1'b1;
              end
            end else if (r_state == ST_PTR) begin
              w_addr_nxt        = r_shift;
              w_state_nxt       = ST_PTR_ACK;
              w_sda_drive_n_nxt = c_ack;
            end else begin
              w_wdata_nxt       = r_shift;
              w_we_nxt          = 1'b1;
              w_state_nxt       = ST_WDATA_ACK;
              w_sda_drive_n_nxt = c_ack;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (w_scl_rise && r_rw == c_rw_read) begin
            w_re_nxt = 1'b1;
          end else if (w_scl_fall) begin
            w_bitcnt_nxt = 4'd0;
            if (r_rw == c_rw_write) begin
              w_state_nxt       = ST_PTR;
              w_sda_drive_n_nxt = 1'b1;
            end else begin
              w_state_nxt       = ST_RDATA;
              w_sda_drive_n_nxt = r_shift[7];
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt       = ST_WDATA;
            w_bitcnt_nxt      = 4'd0;
            w_sda_drive_n_nxt = 1'b1;
          end
        end
        ST_RDATA: begin
          if (w_scl_rise && r_bitcnt != 4'd8) begin
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_scl_fall && r_bitcnt == 4'd8) begin
            w_state_nxt       = ST_RDATA_ACK;
            w_bitcnt_nxt      = 4'd0;
            w_sda_drive_n_nxt = 1'b1;
          end else if (w_scl_fall && r_bitcnt != 4'd0) begin
            w_sda_drive_n_nxt = r_shift[6];
            w_shift_nxt       = {r_shift[6:0], 1'b1};
          end
        end
        ST_RDATA_ACK: begin
          if (w_scl_rise) begin
            if (w_sda == c_nack) begin
              w_state_nxt = ST_IGNORE;
            end else begin
              // Pointer and strobe register together, so reg_re sees the new address.
              w_addr_nxt = r_addr + 8'd1;
              w_re_nxt   = 1'b1;
            end
          end else if (w_scl_fall) begin
            w_state_nxt       = ST_RDATA;
            w_bitcnt_nxt      = 4'd0;
            w_sda_drive_n_nxt = r_shift[7];
          end
        end
        default: begin
          w_sda_drive_n_nxt = 1'b1;
        end
      endcase
    end
  end

  assign i2c_sda_drive_n = r_sda_drive_n;
  assign reg_addr        = r_addr;
  assign reg_wdata       = r_wdata;
  assign reg_we          = r_we;
  assign reg_re          = r_re;
  assign busy            = r_busy;

endmodule

`default_nettype wire

// File: doc/i2c_target.md
# i2c_target

I2C target (responder) exposing an 8-bit-addressed register window to an external I2C controller, so board-management hosts can read and write on-FPGA status and configuration registers. It is the opposite end of the bus from the bringup controller. It shares the same open-drain pad convention: `BB` with I tied to 0 and T driven by `*_drive_n`. It sits beside the DFU core in the `clk` domain and never stretches SCL.

## Interface

Parameters:
- `ADDRESS`, default 7'h30: 7-bit target address this block responds to.
- `FILTER_CYCLES`, default 3: number of consecutive equal synchronized samples required before SCL or SDA is accepted as changed.

Ports:
- `clk` input 1: system clock. Must be at least 16× the SCL frequency.
- `resetn` input 1: asynchronous, active-low reset.
- `i2c_scl_in` input 1: SCL pad input.
- `i2c_sda_in` input 1: SDA pad input.
- `i2c_sda_drive_n` output 1: 0 pulls SDA low; 1 releases SDA.
- `reg_addr` output 8: register pointer.
- `reg_wdata` output 8: write data, valid while `reg_we` is high.
- `reg_we` output 1: one-cycle write strobe.
- `reg_re` output 1: one-cycle read strobe.
- `reg_rdata` input 8: register read data. Must be valid 1 cycle after `reg_re`.
- `busy` output 1: high from an address-matched START until STOP.

## Operation

Input conditioning:
- SCL and SDA each pass through a 2-flop synchronizer, then a glitch filter of `FILTER_CYCLES` samples.
- Edge and condition detection uses the filtered values only:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.

State machine. States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- Bits are sampled MSB-first on the filtered SCL rising edge. SDA output changes only after the filtered SCL falling edge.
- START from any state → ADDR. The bit counter clears.
- STOP from any state → IDLE. SDA is released and `busy` drops.
- ADDR: after 8 bits, if addr[7:1] == `ADDRESS`, go to ADDR_ACK. Otherwise go to IGNORE, which releases SDA and waits for START or STOP.
- ADDR_ACK:
  - SDA is driven low for the 9th bit.
  - Then: R/W=0 → PTR. R/W=1 → pulse `reg_re` and go to RDATA.
- PTR: after 8 bits, the byte loads `reg_addr` → PTR_ACK (ACK) → WDATA.
- WDATA: after 8 bits, `reg_wdata` takes the byte and `reg_we` pulses for 1 cycle → WDATA_ACK (ACK) → WDATA. `reg_addr` increments the cycle after `reg_we`.
- RDATA:
  - The shift register captures `reg_rdata` 1 cycle after `reg_re`.
  - SDA is driven low for 0 bits and released for 1 bits, MSB first.
  - After 8 bits → RDATA_ACK, with SDA released.
- RDATA_ACK:
  - Controller ACK (SDA=0): `reg_addr` increments, `reg_re` pulses, and the state returns to RDATA.
  - Controller NACK: go to IGNORE.
- Repeated START keeps `reg_addr`. This supports write-pointer-then-read sequences.
- `reg_addr` wraps from 8'hFF to 8'h00.

## Timing

- Reset values:
  - `i2c_sda_drive_n`=1; `reg_addr`=8'h00; `reg_wdata`=8'h00; `reg_we`=0; `reg_re`=0; `busy`=0; state=IDLE.
- Asserting `resetn` mid-transfer releases SDA immediately (asynchronously). The block then waits for the next START.
- Filter latency: 2 synchronizer cycles + `FILTER_CYCLES` cycles from a pad change to the internal edge.
- ACK drive: `i2c_sda_drive_n` goes low within 2 cycles after the filtered SCL falling edge that ends bit 8. It is released within 2 cycles after the filtered falling edge that ends bit 9.
- `reg_we` and `reg_re` are exactly 1 cycle wide and never asserted in the same cycle.
- `reg_re` occurs on the 9th-bit rising edge, at least half an SCL period before the first read bit is driven.
- If a START and a STOP are detected in the same cycle, START wins.
- A STOP during a data byte discards the partial byte; no `reg_we` is issued.

## Structure

- A shared package `i2c_pkg` holds:
  - the state enum;
  - the ACK/NACK bit constants;
  - the R/W bit constants.
  The bringup controller uses the same package.
- Sub-module `i2c_line_filter`: synchronizer plus glitch filter for one line, outputting the filtered level plus rise/fall strobes. It is instantiated twice (SCL and SDA).
- Everything else (state machine, shift register, pointer) stays in `i2c_target`.

## Test plan

- Write: START, 0x60, 0x10, 0xA5, 0x5A, STOP → ACK on all four bytes; `reg_we` with (0x10, 0xA5) then (0x11, 0x5A); `busy` falls at STOP.
- Read: START, 0x60, 0x20, repeated START, 0x61; controller ACKs byte 1 and NACKs byte 2, with the model returning addr+0x80 → bytes 0xA0, 0xA1 on SDA; `reg_re` pulses twice; SDA released after the NACK.
- Address mismatch: START, 0x62, 0x00, STOP → SDA never driven; no strobes; `busy` stays 0.
- Pointer wrap: pointer 0xFF, write 3 bytes → `reg_we` addresses 0xFF, 0x00, 0x01.
- Glitch rejection: 1-cycle SCL pulses inserted mid-byte with `FILTER_CYCLES`=3 → received data is unchanged; a 4-cycle pulse is counted as a bit.
- Abort: STOP after 4 bits of a data byte → no `reg_we`, state IDLE. `resetn` low during the ACK bit → `i2c_sda_drive_n`=1 asynchronously.
